axi4l_reg_bridge: RTL and testbench

//  AXI4-Lite slave that converts single AXI read/write transactions into a simple req/ack

---
 rtl/axi4l_reg_bridge.sv | 236 +++++++++++++++++++++++
 tb/tb_axi4l_reg_bridge.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4l_reg_bridge.sv
// axi4l_reg_bridge
//   AXI4-Lite slave that turns one AXI read or write at a time into a req/ack
//   access on a simple register bus. Reads take priority over writes that
//   arrive in the same cycle. A write whose strobes are not all ones is
//   answered with SLVERR and never reaches the register bus.
//
//   Optional macro: AXI4L_REGS_TIMEOUT_EN
//     Defined   : an access that sees no reg_ack within ACK_TIMEOUT cycles of
//                 reg_req is dropped. The bridge answers SLVERR, and a read
//                 returns 32'hDEADBEEF.
//     Undefined : the bridge waits for reg_ack indefinitely.
//
// Ports
//   axi4l_aclk, axi4l_arstn   clock; asynchronous, active-high reset
//   s_axi_aw* / s_axi_w*      write address and data channels (accepted together)
//   s_axi_b*                  write response channel
//   s_axi_ar* / s_axi_r*      read address and read data channels
//   reg_addr/reg_wdata        register word index and write data, held for the whole request
//   reg_wren/reg_req          access request (reg_wren=1 for a write)
//   reg_rdata/reg_ack         one-cycle completion; read data is valid with reg_ack
module axi4l_reg_bridge #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int REG_DATA_WIDTH = 32,
  parameter int ACK_TIMEOUT    = 16
) (
  input  logic                        axi4l_aclk,
  input  logic                        axi4l_arstn,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                        s_axi_awvalid,
  output logic                        s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                        s_axi_wvalid,
  output logic                        s_axi_wready,
  output logic [1:0]                  s_axi_bresp,
  output logic                        s_axi_bvalid,
  input  logic                        s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                        s_axi_arvalid,
  output logic                        s_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                  s_axi_rresp,
  output logic                        s_axi_rvalid,
  input  logic                        s_axi_rready,
  output logic [REG_ADDR_WIDTH-1:0]   reg_addr,
  output logic [REG_DATA_WIDTH-1:0]   reg_wdata,
  output logic                        reg_wren,
  input  logic [REG_DATA_WIDTH-1:0]   reg_rdata,
  output logic                        reg_req,
  input  logic                        reg_ack
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_RESP, S_WR_REQ, S_WR_RESP
  } state_e;

  state_e                    state_q, state_d;
  logic                      arready_q, arready_d;
  logic                      awready_q, awready_d;
  logic                      wready_q, wready_d;
  logic                      bvalid_q, bvalid_d;
  logic                      rvalid_q, rvalid_d;
  logic [1:0]                bresp_q, bresp_d;
  logic [1:0]                rresp_q, rresp_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [REG_ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
  logic [REG_DATA_WIDTH-1:0] reg_wdata_q, reg_wdata_d;
  logic                      reg_wren_q, reg_wren_d;
  logic                      reg_req_q, reg_req_d;
  logic                      wstrb_bad_q, wstrb_bad_d;
  logic                      tmo_hit;

  // Only the word-index bits of the address are used.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_araddr[AXI_ADDR_WIDTH-1:REG_ADDR_WIDTH+2], s_axi_araddr[1:0],
                              s_axi_awaddr[AXI_ADDR_WIDTH-1:REG_ADDR_WIDTH+2], s_axi_awaddr[1:0]};

`ifdef AXI4L_REGS_TIMEOUT_EN
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  // Count the cycles reg_req has been high without an ack. The counter
  // clears on its own once the FSM leaves the request state.
  always_comb begin
    tmo_cnt_d = '0;
    if ((state_q == S_RD_REQ || state_q == S_WR_REQ) && reg_req_q && !reg_ack)
      tmo_cnt_d = tmo_cnt_q + 1'b1;
  end

  always_ff @(posedge axi4l_aclk or posedge axi4l_arstn)
    if (axi4l_arstn) tmo_cnt_q <= '0;
    else             tmo_cnt_q <= tmo_cnt_d;

  assign tmo_hit = reg_req_q && (tmo_cnt_q == TW'(ACK_TIMEOUT - 1));
`else
  localparam int unused_ack_timeout = ACK_TIMEOUT;
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    arready_d   = 1'b0;  // address/data readies are one-cycle pulses
    awready_d   = 1'b0;
    wready_d    = 1'b0;
    bvalid_d    = bvalid_q;
    rvalid_d    = rvalid_q;
    bresp_d     = bresp_q;
    rresp_d     = rresp_q;
    rdata_d     = rdata_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_wren_d  = reg_wren_q;
    reg_req_d   = reg_req_q;
    wstrb_bad_d = wstrb_bad_q;
    case (state_q)
      S_IDLE: begin
        if (s_axi_arvalid) begin
          arready_d  = 1'b1;
          reg_addr_d = s_axi_araddr[REG_ADDR_WIDTH+1:2];
          state_d    = S_RD_REQ;
        end else if (s_axi_awvalid && s_axi_wvalid) begin
          awready_d   = 1'b1;
          wready_d    = 1'b1;
          reg_addr_d  = s_axi_awaddr[REG_ADDR_WIDTH+1:2];
          reg_wdata_d = s_axi_wdata;
          wstrb_bad_d = (s_axi_wstrb != '1);
          state_d     = S_WR_REQ;
        end
      end
      // reg_req rises one cycle after the address pulse. An ack only counts
      // while reg_req is already high, so a stray ack is ignored.
      S_RD_REQ: begin
        if (reg_req_q && reg_ack) begin
          reg_req_d = 1'b0;
          rdata_d   = reg_rdata;
          rresp_d   = RESP_OKAY;
          rvalid_d  = 1'b1;
          state_d   = S_RD_RESP;
        end else if (tmo_hit) begin
          reg_req_d = 1'b0;
          rdata_d   = AXI_DATA_WIDTH'(32'hDEADBEEF);
          rresp_d   = RESP_SLVERR;
          rvalid_d  = 1'b1;
          state_d   = S_RD_RESP;
        end else begin
          reg_req_d = 1'b1;
        end
      end
      S_WR_REQ: begin
        if (wstrb_bad_q) begin
          // A partial-strobe write never reaches the register bus.
          bvalid_d = 1'b1;
          bresp_d  = RESP_SLVERR;
          state_d  = S_WR_RESP;
        end else if (reg_req_q && reg_ack) begin
          reg_req_d  = 1'b0;
          reg_wren_d = 1'b0;
          bvalid_d   = 1'b1;
          bresp_d    = RESP_OKAY;
          state_d    = S_WR_RESP;
        end else if (tmo_hit) begin
          reg_req_d  = 1'b0;
          reg_wren_d = 1'b0;
          bvalid_d   = 1'b1;
          bresp_d    = RESP_SLVERR;
          state_d    = S_WR_RESP;
        end else begin
          reg_req_d  = 1'b1;
          reg_wren_d = 1'b1;
        end
      end
      S_RD_RESP: if (s_axi_rready) begin
        rvalid_d = 1'b0;
        state_d  = S_IDLE;
      end
      S_WR_RESP: if (s_axi_bready) begin
        bvalid_d = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge axi4l_aclk or posedge axi4l_arstn) begin
    if (axi4l_arstn) begin
      state_q     <= S_IDLE;
      arready_q   <= 1'b0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      rvalid_q    <= 1'b0;
      bresp_q     <= RESP_OKAY;
      rresp_q     <= RESP_OKAY;
      rdata_q     <= '0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_wren_q  <= 1'b0;
      reg_req_q   <= 1'b0;
      wstrb_bad_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      arready_q   <= arready_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      rvalid_q    <= rvalid_d;
      bresp_q     <= bresp_d;
      rresp_q     <= rresp_d;
      rdata_q     <= rdata_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_wren_q  <= reg_wren_d;
      reg_req_q   <= reg_req_d;
      wstrb_bad_q <= wstrb_bad_d;
    end
  end

  assign s_axi_arready = arready_q;
  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;
  assign reg_addr      = reg_addr_q;
  assign reg_wdata     = reg_wdata_q;
  assign reg_wren      = reg_wren_q;
  assign reg_req       = reg_req_q;

endmodule

// File: tb/tb_axi4l_reg_bridge.sv
// Bench for axi4l_reg_bridge.
// A behavioural register block answers reg_req after a random delay. An
// expected-contents array, updated from the AXI-level rules, predicts every
// response and read value.
module tb_axi4l_reg_bridge;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] awaddr, wdata, araddr, rdata, reg_wdata, reg_rdata;
  logic [3:0]  wstrb, reg_addr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;
  logic        reg_wren, reg_req, reg_ack;

  always #5 clk = ~clk;

  axi4l_reg_bridge dut (
    .axi4l_aclk(clk), .axi4l_arstn(rst),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wren(reg_wren),
    .reg_rdata(reg_rdata), .reg_req(reg_req), .reg_ack(reg_ack)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Register block behaviour plus the bench's expected contents.
  logic [31:0] mem [16];
  logic [31:0] exp_mem [16];
  logic        ack_en = 1'b1, fast_ack = 1'b0, stray_ack = 1'b0, in_req = 1'b0;
  int          dly = 0, nacc = 0;
  logic [3:0]  last_addr, req_addr;
  logic [31:0] last_wdata, req_wdata;
  logic        last_wren;

  initial begin
    reg_ack = 1'b0; reg_rdata = '0;
    forever begin
      @(negedge clk);
      reg_ack = stray_ack;
      if (!reg_req) in_req = 1'b0;
      else begin
        if (!in_req) begin
          in_req = 1'b1; req_addr = reg_addr; req_wdata = reg_wdata;
          dly = fast_ack ? 0 : int'($urandom_range(0, 3));
        end
        if (ack_en) begin
          if (dly == 0) begin
            chk("req_stable", {reg_addr, reg_wdata[27:0]}, {req_addr, req_wdata[27:0]});
            reg_ack = 1'b1;
            reg_rdata = mem[reg_addr];
            if (reg_wren) mem[reg_addr] = reg_wdata;
            last_addr = reg_addr; last_wren = reg_wren; last_wdata = reg_wdata;
            nacc++;
            in_req = 1'b0;
          end else dly--;
        end
      end
    end
  end

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int hold, output logic [1:0] resp, output time t_acc);
    int n;
    logic ok;
    @(posedge clk); #1 awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!awready && n < 200);
    if (!awready) chk("aw_wait_expired", 0, 1);
    chk("aw_w_together", {31'd0, wready}, 1);
    t_acc = $time;
    @(posedge clk); #1 awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bvalid && n < 200);
    if (!bvalid) chk("b_wait_expired", 0, 1);
    resp = bresp;
    ok = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      if (!bvalid || bresp !== resp || awready || arready) ok = 1'b0;
    end
    if (hold > 0) chk("b_hold_stable", {31'd0, ok}, 1);
    @(posedge clk); #1 bready = 1'b1;
    @(posedge clk); #1 bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, input int hold, output logic [31:0] d,
                          output logic [1:0] resp, output time t_acc, output int lat);
    int n;
    logic ok;
    @(posedge clk); #1 araddr = a; arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < 200);
    if (!arready) chk("ar_wait_expired", 0, 1);
    t_acc = $time;
    @(posedge clk); #1 arvalid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rvalid && n < 200);
    if (!rvalid) chk("r_wait_expired", 0, 1);
    lat = n; d = rdata; resp = rresp;
    ok = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      if (!rvalid || rdata !== d || rresp !== resp || arready || awready) ok = 1'b0;
    end
    if (hold > 0) chk("r_hold_stable", {31'd0, ok}, 1);
    @(posedge clk); #1 rready = 1'b1;
    @(posedge clk); #1 rready = 1'b0;
  endtask

  logic [31:0] d, a, v;
  logic [1:0]  r, r2;
  logic [3:0]  s;
  time         t1, t2;
  int          lat, n0;

  initial begin
    for (int i = 0; i < 16; i++) begin mem[i] = 32'h1111_1111 * i; exp_mem[i] = mem[i]; end
    rst = 1'b1; awaddr = '0; wdata = '0; wstrb = '0; awvalid = 0; wvalid = 0; bready = 0;
    araddr = '0; arvalid = 0; rready = 0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("rst_handshakes", {26'd0, arready, awready, wready, bvalid, rvalid, reg_req}, 0);
    chk("rst_reg_side", {reg_addr, reg_wren, 27'd0}, 0);
    chk("rst_reg_wdata", reg_wdata, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_resp", {28'd0, bresp, rresp}, 0);
    @(posedge clk); #1 rst = 1'b0;

    // First write after reset.
    axi_write(32'h8000_0004, 32'hA5A5_1234, 4'hF, 0, r, t1);
    exp_mem[1] = 32'hA5A5_1234;
    chk("wr1_bresp", {30'd0, r}, 0);
    chk("wr1_addr_wren", {27'd0, last_addr, last_wren}, {27'd0, 4'd1, 1'b1});
    chk("wr1_wdata", last_wdata, 32'hA5A5_1234);

    // Fill indices 0, 2, 3, then read 0..3 back in order.
    for (int i = 0; i < 4; i += 1) if (i != 1) begin
      v = 32'hC0DE_0000 + i;
      axi_write(32'h8000_0000 + 4 * i, v, 4'hF, 0, r, t1);
      exp_mem[i] = v;
      chk("fill_bresp", {30'd0, r}, 0);
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(32'h8000_0000 + 4 * i, 0, d, r, t1, lat);
      chk("seq_rd_addr", {28'd0, last_addr}, i);
      chk("seq_rd_data", d, exp_mem[i]);
      chk("seq_rd_rresp", {30'd0, r}, 0);
    end

    // Minimum latency: arready seen, then rvalid two cycles later.
    fast_ack = 1'b1;
    axi_read(32'h0000_0008, 0, d, r, t1, lat);
    chk("min_latency", lat, 2);
    chk("min_lat_data", d, exp_mem[2]);
    fast_ack = 1'b0;

    // Read and write presented together: the read is served first.
    fork
      axi_read(32'h0000_000C, 0, d, r, t1, lat);
      axi_write(32'h0000_000C, 32'h5555_AAAA, 4'hF, 0, r2, t2);
    join
    chk("simul_read_old", d, exp_mem[3]);
    exp_mem[3] = 32'h5555_AAAA;
    chk("simul_read_first", {31'd0, t1 < t2}, 1);
    chk("simul_bresp", {28'd0, r, r2}, 0);
    axi_read(32'h0000_000C, 0, d, r, t1, lat);
    chk("simul_write_done", d, 32'h5555_AAAA);

    // Response backpressure for five cycles.
    axi_read(32'h0000_0004, 5, d, r, t1, lat);
    chk("bp_rdata", d, exp_mem[1]);
    axi_write(32'h0000_0010, 32'h1234_5678, 4'hF, 5, r, t1);
    exp_mem[4] = 32'h1234_5678;
    chk("bp_bresp", {30'd0, r}, 0);

    // Partial strobes: no register access, SLVERR.
    n0 = nacc;
    axi_write(32'h0000_0014, 32'hFFFF_FFFF, 4'h3, 0, r, t1);
    chk("strb_bresp", {30'd0, r}, 2);
    chk("strb_no_access", nacc, n0);

    // A stray ack while idle must not start anything.
    @(posedge clk); #1 stray_ack = 1'b1;
    repeat (3) @(negedge clk);
    chk("stray_ack_idle", {29'd0, rvalid, bvalid, reg_req}, 0);
    @(posedge clk); #1 stray_ack = 1'b0;

    // Random traffic with random upper address bits; the index wraps mod 16.
    for (int k = 0; k < 40; k++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        v = $urandom;
        s = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
        axi_write(a, v, s, $urandom_range(0, 3), r, t1);
        if (s == 4'hF) exp_mem[a[5:2]] = v;
        chk("rnd_bresp", {30'd0, r}, (s == 4'hF) ? 0 : 2);
      end else begin
        axi_read(a, $urandom_range(0, 3), d, r, t1, lat);
        chk("rnd_rdata", d, exp_mem[a[5:2]]);
        chk("rnd_rresp", {30'd0, r}, 0);
      end
    end

    // Reset in the middle of a read: no response is issued.
    ack_en = 1'b0;
    @(posedge clk); #1 araddr = 32'h0; arvalid = 1'b1;
    repeat (4) @(posedge clk);
    #1 arvalid = 1'b0; rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_quiet", {28'd0, rvalid, bvalid, reg_req, arready}, 0);
    @(posedge clk); #1 rst = 1'b0; ack_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_no_resp", {31'd0, rvalid}, 0);
    axi_read(32'h0000_0000, 0, d, r, t1, lat);
    chk("midrst_after_read", d, exp_mem[0]);

`ifdef AXI4L_REGS_TIMEOUT_EN
    ack_en = 1'b0;
    axi_read(32'h0000_0008, 0, d, r, t1, lat);
    chk("tmo_rresp", {30'd0, r}, 2);
    chk("tmo_rdata", d, 32'hDEADBEEF);
    ack_en = 1'b1;
`endif

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit got=%0d exp=%0d", checks, 0);
    $fatal(1, "time limit");
  end
endmodule
